block_pair_issuer: RTL and testbench

Upstream feeder for `inter_layer_block_scheduler`. Buffers a stream of per-block descriptors (direction, start, length) in a small FIFO. Pairs consecutive descriptors, encodes the pair's `block_type`, and presents the pair on the scheduler's `schedule_valid`/`schedule_ready` handshake. Holds each pair stable until the scheduler accepts it, and counts issued pairs for host status.

---
 rtl/block_pair_issuer.sv | 208 ++++++++++++++++++++
 tb/tb_block_pair_issuer.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/block_pair_issuer.sv
`default_nettype none
// ============================================================================
// Module   : block_pair_issuer
// Brief    : Buffers block descriptors, pairs consecutive entries and issues
//            each pair on a valid/ready handshake to the layer scheduler.
//            Optional macro ISSUER_LENGTH_CHECK_EN drops zero-length pushes
//            and raises a sticky err_o.
// Revision : 1.0 - initial release
// ============================================================================

`ifndef FORWARD_FORWARD
`define FORWARD_FORWARD   2'b00
`endif
`ifndef FORWARD_BACKWARD
`define FORWARD_BACKWARD  2'b01
`endif
`ifndef BACKWARD_FORWARD
`define BACKWARD_FORWARD  2'b10
`endif
`ifndef BACKWARD_BACKWARD
`define BACKWARD_BACKWARD 2'b11
`endif

module block_pair_issuer #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   desc_valid_i,
    output logic                   desc_ready_o,
    input  logic                   desc_dir_i,
    input  logic [31:0]            desc_start_i,
    input  logic [31:0]            desc_length_i,
    input  logic                   flush_i,
    output logic [1:0]             block_type_o,
    output logic [31:0]            block0_start_o,
    output logic [31:0]            block1_start_o,
    output logic [31:0]            block0_length_o,
    output logic [31:0]            block1_length_o,
    output logic                   schedule_valid_o,
    input  logic                   schedule_ready_i,
    output logic [$clog2(DEPTH):0] fifo_count_o,
    output logic [CNT_W-1:0]       pairs_issued_o,
    output logic                   err_o
);

    localparam int                 c_ptr_w    = $clog2(DEPTH);
    localparam int                 c_cnt_w    = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_full     = c_cnt_w'(DEPTH);
    localparam logic [0:0]         c_st_idle  = 1'b0;
    localparam logic [0:0]         c_st_issue = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_next;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w-1:0] w_rd_ptr1;
    logic [c_cnt_w-1:0] r_count;
    logic [c_cnt_w-1:0] w_pop_n;
    logic               r_mem_dir   [DEPTH];
    logic [31:0]        r_mem_start [DEPTH];
    logic [31:0]        r_mem_len   [DEPTH];
    logic               w_push_hs;
    logic               w_write;
    logic               w_pop2;
    logic               w_pop1;
    logic               w_dir0;
    logic               w_dir1;
    logic [1:0]         w_type;
    logic [1:0]         r_type;
    logic [31:0]        r_b0_start;
    logic [31:0]        r_b0_len;
    logic [31:0]        r_b1_start;
    logic [31:0]        r_b1_len;
    logic [CNT_W-1:0]   r_pairs;

    assign desc_ready_o = (r_count != c_full);
    assign w_push_hs    = desc_valid_i && desc_ready_o;

`ifdef ISSUER_LENGTH_CHECK_EN
    logic r_err;

    // Zero-length pushes complete the handshake but never reach storage.
    assign w_write = w_push_hs && (desc_length_i != 32'd0);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_err <= 1'b0;
        end else if (w_push_hs && (desc_length_i == 32'd0)) begin
            r_err <= 1'b1;
        end
    end

    assign err_o = r_err;
`else
    assign w_write = w_push_hs;
    assign err_o   = 1'b0;
`endif

    assign w_pop2    = (r_state == c_st_idle) && (r_count >= c_cnt_w'(2));
    assign w_pop1    = (r_state == c_st_idle) && (r_count == c_cnt_w'(1)) && flush_i;
    assign w_pop_n   = w_pop2 ? c_cnt_w'(2) : (w_pop1 ? c_cnt_w'(1) : c_cnt_w'(0));
    assign w_rd_ptr1 = r_rd_ptr + c_ptr_w'(1);

    // A lone flushed descriptor is mirrored into block1 with its own direction.
    assign w_dir0 = r_mem_dir[r_rd_ptr];
    assign w_dir1 = w_pop2 ? r_mem_dir[w_rd_ptr1] : w_dir0;

    always_comb begin
        w_type = `FORWARD_FORWARD;
        case ({w_dir0, w_dir1})
            2'b00:   w_type = `FORWARD_FORWARD;
            2'b01:   w_type = `FORWARD_BACKWARD;
            2'b10:   w_type = `BACKWARD_FORWARD;
            default: w_type = `BACKWARD_BACKWARD;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (w_write) begin
            r_mem_dir[r_wr_ptr]   <= desc_dir_i;
            r_mem_start[r_wr_ptr] <= desc_start_i;
            r_mem_len[r_wr_ptr]   <= desc_length_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop2) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(2);
            end else if (w_pop1) begin
                r_rd_ptr <= w_rd_ptr1;
            end
            r_count <= r_count + c_cnt_w'(w_write) - w_pop_n;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_type     <= 2'b00;
            r_b0_start <= '0;
            r_b0_len   <= '0;
            r_b1_start <= '0;
            r_b1_len   <= '0;
        end else if (w_pop2 || w_pop1) begin
            r_type     <= w_type;
            r_b0_start <= r_mem_start[r_rd_ptr];
            r_b0_len   <= r_mem_len[r_rd_ptr];
            r_b1_start <= w_pop2 ? r_mem_start[w_rd_ptr1] : r_mem_start[r_rd_ptr];
            r_b1_len   <= w_pop2 ? r_mem_len[w_rd_ptr1] : 32'd0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_pairs <= '0;
        end else if ((r_state == c_st_issue) && schedule_ready_i) begin
            r_pairs <= r_pairs + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_pop2 || w_pop1) begin
                    w_state_next = c_st_issue;
                end
            end
            default: begin
                if (schedule_ready_i) begin
                    w_state_next = c_st_idle;
                end
            end
        endcase
    end

    always_comb begin
        schedule_valid_o = (r_state == c_st_issue);
    end

    assign block_type_o    = r_type;
    assign block0_start_o  = r_b0_start;
    assign block0_length_o = r_b0_len;
    assign block1_start_o  = r_b1_start;
    assign block1_length_o = r_b1_len;
    assign fifo_count_o    = r_count;
    assign pairs_issued_o  = r_pairs;

endmodule

`default_nettype wire

// File: tb/tb_block_pair_issuer.sv
`default_nettype none
// ============================================================================
// Module   : tb_block_pair_issuer
// Brief    : Scoreboard bench for block_pair_issuer; expected pairs are built
//            from driven descriptors and compared at each accepted handshake.
// Revision : 1.0 - initial release
// ============================================================================

module tb_block_pair_issuer;

    localparam int DEPTH = 8;
    localparam int CNT_W = 16;

    logic                   clk;
    logic                   rst_n;
    logic                   desc_valid;
    logic                   desc_ready;
    logic                   desc_dir;
    logic [31:0]            desc_start;
    logic [31:0]            desc_length;
    logic                   flush;
    logic [1:0]             block_type;
    logic [31:0]            b0_start;
    logic [31:0]            b1_start;
    logic [31:0]            b0_len;
    logic [31:0]            b1_len;
    logic                   schedule_valid;
    logic                   schedule_ready;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [CNT_W-1:0]       pairs_issued;
    logic                   err;

    typedef struct packed {
        logic [1:0]  typ;
        logic [31:0] s0;
        logic [31:0] l0;
        logic [31:0] s1;
        logic [31:0] l1;
    } pair_t;

    pair_t       exp_q[$];
    bit          have_pend;
    logic        pend_dir;
    logic [31:0] pend_start;
    logic [31:0] pend_len;
    int          total;
    int          bad;

    block_pair_issuer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .desc_valid_i     (desc_valid),
        .desc_ready_o     (desc_ready),
        .desc_dir_i       (desc_dir),
        .desc_start_i     (desc_start),
        .desc_length_i    (desc_length),
        .flush_i          (flush),
        .block_type_o     (block_type),
        .block0_start_o   (b0_start),
        .block1_start_o   (b1_start),
        .block0_length_o  (b0_len),
        .block1_length_o  (b1_len),
        .schedule_valid_o (schedule_valid),
        .schedule_ready_i (schedule_ready),
        .fifo_count_o     (fifo_count),
        .pairs_issued_o   (pairs_issued),
        .err_o            (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_add(input logic dir, input logic [31:0] s, input logic [31:0] l);
`ifdef ISSUER_LENGTH_CHECK_EN
        if (l == 32'd0) return;
`endif
        if (have_pend) begin
            exp_q.push_back({{pend_dir, dir}, pend_start, pend_len, s, l});
            have_pend = 1'b0;
        end else begin
            have_pend  = 1'b1;
            pend_dir   = dir;
            pend_start = s;
            pend_len   = l;
        end
    endfunction

    function automatic void model_flush();
        if (have_pend) begin
            exp_q.push_back({{pend_dir, pend_dir}, pend_start, pend_len, pend_start, 32'd0});
            have_pend = 1'b0;
        end
    endfunction

    // Inputs are set at the falling edge; an acceptance seen here completes at the next rising edge.
    task automatic tick();
        pair_t act;
        pair_t e;
        if (schedule_valid && schedule_ready) begin
            act = {block_type, b0_start, b0_len, b1_start, b1_len};
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL pair_unexpected: got %h, scoreboard empty", act);
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    bad++;
                    $display("FAIL pair_value: got %h want %h", act, e);
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input logic dir, input logic [31:0] s, input logic [31:0] l);
        int w;
        w           = 0;
        desc_valid  = 1'b1;
        desc_dir    = dir;
        desc_start  = s;
        desc_length = l;
        while (!desc_ready && w < 50) begin
            tick();
            w++;
        end
        if (!desc_ready) begin
            total++;
            bad++;
            $display("FAIL push_timeout: desc_ready got 0 want 1");
        end else begin
            tick();
            model_add(dir, s, l);
        end
        desc_valid = 1'b0;
    endtask

    task automatic drain();
        schedule_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (!schedule_valid && fifo_count < 2) break;
            tick();
        end
        schedule_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        total++;
        if ({schedule_valid, block_type} !== 3'b000) begin
            bad++; $display("FAIL reset_valid_type: got %b want 000", {schedule_valid, block_type});
        end
        total++;
        if ({b0_start, b0_len, b1_start, b1_len} !== 128'd0) begin
            bad++; $display("FAIL reset_pair: got %h want 0", {b0_start, b0_len, b1_start, b1_len});
        end
        total++;
        if ({fifo_count, pairs_issued, err} !== '0) begin
            bad++; $display("FAIL reset_status: count=%0d pairs=%0d err=%b want 0/0/0", fifo_count, pairs_issued, err);
        end
        rst_n = 1'b1;
        tick();
        total++;
        if (desc_ready !== 1'b1 || schedule_valid !== 1'b0) begin
            bad++; $display("FAIL reset_release: ready=%b valid=%b want 1/0", desc_ready, schedule_valid);
        end
    endtask

    task automatic test_reset_mid();
        schedule_ready = 1'b0;
        push(1'b0, 32'd1, 32'd1);
        push(1'b1, 32'd2, 32'd2);
        push(1'b0, 32'd3, 32'd3);
        push(1'b1, 32'd4, 32'd4);
        push(1'b0, 32'd5, 32'd5);
        total++;
        if (schedule_valid !== 1'b1 || fifo_count !== 4'd3) begin
            bad++; $display("FAIL mid_pre: valid=%b count=%0d want 1/3", schedule_valid, fifo_count);
        end
        rst_n = 1'b0;
        tick();
        total++;
        if (schedule_valid !== 1'b0 || fifo_count !== 4'd0 || pairs_issued !== 16'd0) begin
            bad++; $display("FAIL mid_reset: valid=%b count=%0d pairs=%0d want 0/0/0", schedule_valid, fifo_count, pairs_issued);
        end
        exp_q.delete();
        have_pend = 1'b0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_hold();
        schedule_ready = 1'b0;
        push(1'b0, 32'd4, 32'd4);
        push(1'b0, 32'd0, 32'd4);
        total++;
        if (fifo_count !== 4'd2 || schedule_valid !== 1'b0) begin
            bad++; $display("FAIL hold_latency_n: count=%0d valid=%b want 2/0", fifo_count, schedule_valid);
        end
        tick();
        total++;
        if (fifo_count !== 4'd0 || schedule_valid !== 1'b1) begin
            bad++; $display("FAIL hold_latency_n1: count=%0d valid=%b want 0/1", fifo_count, schedule_valid);
        end
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({schedule_valid, block_type, b0_start, b0_len, b1_start, b1_len} !==
                {1'b1, 2'b00, 32'd4, 32'd4, 32'd0, 32'd4}) begin
                bad++; $display("FAIL hold_stable: cycle %0d got v=%b t=%b %0d/%0d %0d/%0d want v=1 t=00 4/4 0/4",
                                i, schedule_valid, block_type, b0_start, b0_len, b1_start, b1_len);
            end
            tick();
        end
        schedule_ready = 1'b1;
        tick();
        schedule_ready = 1'b0;
        total++;
        if (pairs_issued !== 16'd1 || schedule_valid !== 1'b0 || exp_q.size() != 0) begin
            bad++; $display("FAIL hold_accept: pairs=%0d valid=%b left=%0d want 1/0/0", pairs_issued, schedule_valid, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic        dirs [4];
        logic [31:0] sts  [4];
        bit          acc;
        dirs = '{1'b0, 1'b1, 1'b1, 1'b0};
        sts  = '{32'd0, 32'd4, 32'd0, 32'd4};
        schedule_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            desc_valid = (i < 4);
            if (i < 4) begin
                desc_dir    = dirs[i];
                desc_start  = sts[i];
                desc_length = 32'd4;
                if (desc_ready) model_add(dirs[i], sts[i], 32'd4);
            end
            acc = schedule_valid && schedule_ready;
            tick();
            if (acc) begin
                total++;
                if (schedule_valid !== 1'b0) begin
                    bad++; $display("FAIL b2b_gap: valid got 1 want 0 after acceptance (cycle %0d)", i);
                end
            end
            if (i == 1) begin
                total++;
                if (fifo_count !== 4'd2) begin
                    bad++; $display("FAIL b2b_count: got %0d want 2", fifo_count);
                end
            end
        end
        desc_valid     = 1'b0;
        schedule_ready = 1'b0;
        total++;
        if (pairs_issued !== 16'd3 || exp_q.size() != 0) begin
            bad++; $display("FAIL b2b_pairs: pairs=%0d left=%0d want 3/0", pairs_issued, exp_q.size());
        end
    endtask

    task automatic test_full();
        int n;
        n = 0;
        schedule_ready = 1'b0;
        while (desc_ready && n < DEPTH + 4) begin
            desc_valid  = 1'b1;
            desc_dir    = n[0];
            desc_start  = 32'd100 + 32'(n);
            desc_length = 32'(n) + 32'd1;
            tick();
            model_add(n[0], 32'd100 + 32'(n), 32'(n) + 32'd1);
            n++;
        end
        total++;
        if (n != DEPTH + 2 || fifo_count !== 4'(DEPTH) || desc_ready !== 1'b0) begin
            bad++; $display("FAIL full_level: pushed=%0d count=%0d ready=%b want %0d/%0d/0", n, fifo_count, desc_ready, DEPTH + 2, DEPTH);
        end
        desc_valid  = 1'b1;
        desc_dir    = 1'b1;
        desc_start  = 32'd999;
        desc_length = 32'd9;
        tick();
        tick();
        tick();
        desc_valid = 1'b0;
        total++;
        if (fifo_count !== 4'(DEPTH)) begin
            bad++; $display("FAIL full_stall: count got %0d want %0d", fifo_count, DEPTH);
        end
        schedule_ready = 1'b1;
        tick();
        schedule_ready = 1'b0;
        tick();
        total++;
        if (fifo_count !== 4'(DEPTH - 2) || desc_ready !== 1'b1 || schedule_valid !== 1'b1) begin
            bad++; $display("FAIL full_free: count=%0d ready=%b valid=%b want %0d/1/1", fifo_count, desc_ready, schedule_valid, DEPTH - 2);
        end
        drain();
        total++;
        if (pairs_issued !== 16'd8 || exp_q.size() != 0) begin
            bad++; $display("FAIL full_drain: pairs=%0d left=%0d want 8/0", pairs_issued, exp_q.size());
        end
    endtask

    task automatic test_flush();
        schedule_ready = 1'b0;
        flush = 1'b1;
        tick();
        tick();
        flush = 1'b0;
        total++;
        if (schedule_valid !== 1'b0) begin
            bad++; $display("FAIL flush_empty: valid got 1 want 0");
        end
        push(1'b1, 32'd7, 32'd3);
        for (int i = 0; i < 10; i++) tick();
        total++;
        if (schedule_valid !== 1'b0 || fifo_count !== 4'd1) begin
            bad++; $display("FAIL flush_wait: valid=%b count=%0d want 0/1", schedule_valid, fifo_count);
        end
        flush = 1'b1;
        model_flush();
        tick();
        flush = 1'b0;
        total++;
        if ({schedule_valid, block_type, b0_start, b0_len, b1_start, b1_len} !==
            {1'b1, 2'b11, 32'd7, 32'd3, 32'd7, 32'd0}) begin
            bad++; $display("FAIL flush_pair: got v=%b t=%b %0d/%0d %0d/%0d want v=1 t=11 7/3 7/0",
                            schedule_valid, block_type, b0_start, b0_len, b1_start, b1_len);
        end
        schedule_ready = 1'b1;
        tick();
        schedule_ready = 1'b0;
        total++;
        if (pairs_issued !== 16'd9 || exp_q.size() != 0 || fifo_count !== 4'd0) begin
            bad++; $display("FAIL flush_accept: pairs=%0d left=%0d count=%0d want 9/0/0", pairs_issued, exp_q.size(), fifo_count);
        end
    endtask

    task automatic test_length_check();
        logic        exp_err;
        logic [15:0] exp_pairs;
`ifdef ISSUER_LENGTH_CHECK_EN
        exp_err   = 1'b1;
        exp_pairs = 16'd10;
`else
        exp_err   = 1'b0;
        exp_pairs = 16'd11;
`endif
        schedule_ready = 1'b0;
        push(1'b0, 32'd2, 32'd0);
        push(1'b0, 32'd10, 32'd5);
        push(1'b1, 32'd20, 32'd6);
        drain();
        if (have_pend) begin
            flush = 1'b1;
            model_flush();
            tick();
            flush = 1'b0;
            drain();
        end
        for (int i = 0; i < 3; i++) tick();
        total++;
        if (err !== exp_err) begin
            bad++; $display("FAIL len_err: got %b want %b", err, exp_err);
        end
        total++;
        if (pairs_issued !== exp_pairs || exp_q.size() != 0 || fifo_count !== 4'd0) begin
            bad++; $display("FAIL len_pairs: pairs=%0d left=%0d count=%0d want %0d/0/0", pairs_issued, exp_q.size(), fifo_count, exp_pairs);
        end
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        have_pend      = 1'b0;
        rst_n          = 1'b0;
        desc_valid     = 1'b0;
        desc_dir       = 1'b0;
        desc_start     = '0;
        desc_length    = '0;
        flush          = 1'b0;
        schedule_ready = 1'b0;
        test_reset();
        test_reset_mid();
        test_hold();
        test_back_to_back();
        test_full();
        test_flush();
        test_length_check();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
